// File: rtl/uart_cmd_framer.sv
// Packs BYTES_PER_CMD UART bytes (first byte = MSB) into commands held in a CMD_DEPTH-entry FIFO.
// Define CMD_TIMEOUT_EN to add inter-byte timeout resync; otherwise frame_err_o is tied low.
module uart_cmd_framer #(
  parameter int BYTES_PER_CMD = 2,
  parameter int CMD_DEPTH     = 2,
  parameter int TIMEOUT_CYC   = 50000
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           rx_rdy_i,
  input  logic [7:0]                     rx_data_i,
  output logic                           clr_rx_rdy_o,
  input  logic                           clr_cmd_rdy_i,
  input  logic                           flush_i,
  output logic                           cmd_rdy_o,
  output logic [8*BYTES_PER_CMD-1:0]     cmd_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_cnt_o,
  output logic                           overflow_o,
  output logic                           frame_err_o
);
  localparam int CMD_W = 8 * BYTES_PER_CMD;
  localparam int ASM_W = 8 * (BYTES_PER_CMD - 1);
  localparam int IDX_W = $clog2(BYTES_PER_CMD);
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_CMD - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CMD_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;
  logic [CMD_W-1:0] mem_q [CMD_DEPTH];

  logic             accept, timeout, last_byte, push, pop, full, wr_en;
  logic [CMD_W-1:0] push_dat;

  // Every presented byte is consumed, even during flush when it is discarded.
  assign clr_rx_rdy_o = rx_rdy_i;
  assign accept       = rx_rdy_i && !flush_i;
  assign full         = (count_q == FULL_CNT);
  assign pop          = clr_cmd_rdy_i && (count_q != '0) && !flush_i;
  assign last_byte    = (byte_idx_q == LAST_IDX) && !timeout;
  assign push         = accept && last_byte;
  assign wr_en        = push && (!full || pop);
  assign push_dat     = {asm_q, rx_data_i};

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout = (byte_idx_q != '0) && (tmo_cnt_q == TMO_LAST) && !flush_i;

  always_comb begin
    tmo_cnt_d = '0;
    if (!flush_i && !accept && !timeout && (byte_idx_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_err_d = timeout;
    if (flush_i) begin
      byte_idx_d = '0;
      asm_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        // A byte landing in the timeout cycle starts a fresh frame.
        if (timeout) begin
          byte_idx_d = IDX_W'(1);
          asm_d      = ASM_W'(rx_data_i);
        end else if (last_byte) begin
          byte_idx_d = '0;
          asm_d      = '0;
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
          asm_d      = ASM_W'({asm_q, rx_data_i});
        end
      end else if (timeout) begin
        byte_idx_d = '0;
        asm_d      = '0;
      end
      if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && full && !pop) overflow_d = 1'b1;
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byte_idx_q  <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign cmd_rdy_o   = (count_q != '0);
  assign cmd_o       = mem_q[rd_ptr_q];
  assign cmd_cnt_o   = count_q;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule
